// File: rtl/regbus_sequencer_if.sv
// Request/operand/result handshake between the execute logic and
// regbus_sequencer. The register-file side (tristate bus, index, strobes)
// stays on plain ports of the sequencer.
interface regbus_sequencer_if;
    logic        start;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        wb;
    logic        busy;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        opnd_valid;
    logic [31:0] result;
    logic        result_valid;
    logic        done;

    // Execute-logic side: issues requests and returns results.
    modport master (
        output start, rs1, rs2, rd, wb, result, result_valid,
        input  busy, op_a, op_b, opnd_valid, done
    );

    // Sequencer side: accepts requests and presents operands.
    modport slave (
        input  start, rs1, rs2, rd, wb, result, result_valid,
        output busy, op_a, op_b, opnd_valid, done
    );
endinterface

// File: rtl/regbus_sequencer.sv
// regbus_sequencer: bus master for the 32-entry register file. Reads rs1 and
// rs2 over the shared tristate bus, presents them to the execute logic, waits
// for a result and writes it back to rd. Index 0 is never read over the bus
// and never written. Every output is a register, so the bus drive enable and
// all strobes fall as soon as rst_n is asserted.
module regbus_sequencer (
    input  logic               clk,
    input  logic               rst_n,
    regbus_sequencer_if.slave  req,
    inout  wire  [31:0]        bus,
    output logic [4:0]         reg_idx,
    output logic               reg_en,
    output logic               reg_write
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD_A = 3'd1,
        S_RD_B = 3'd2,
        S_WAIT = 3'd3,
        S_WR   = 3'd4,
        S_FIN  = 3'd5
    } state_t;

    state_t      state_r;
    logic [4:0]  rs1_r;
    logic [4:0]  rs2_r;
    logic [4:0]  rd_r;
    logic        wb_r;
    logic [31:0] op_a_r;
    logic [31:0] op_b_r;
    logic [31:0] wb_data_r;
    logic        busy_r;
    logic        opnd_valid_r;
    logic        done_r;
    logic        bus_oe_r;
    logic [4:0]  reg_idx_r;
    logic        reg_en_r;
    logic        reg_write_r;

    // Transaction FSM; every output flag is updated here together with the
    // state so that each output is a plain register (no input-to-output path).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= S_IDLE;
            rs1_r        <= 5'd0;
            rs2_r        <= 5'd0;
            rd_r         <= 5'd0;
            wb_r         <= 1'b0;
            op_a_r       <= 32'd0;
            op_b_r       <= 32'd0;
            wb_data_r    <= 32'd0;
            busy_r       <= 1'b0;
            opnd_valid_r <= 1'b0;
            done_r       <= 1'b0;
            bus_oe_r     <= 1'b0;
            reg_idx_r    <= 5'd0;
            reg_en_r     <= 1'b0;
            reg_write_r  <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (req.start) begin
                        // Capture the request and set up the rs1 read so the
                        // register file sees the index during RD_A.
                        rs1_r     <= req.rs1;
                        rs2_r     <= req.rs2;
                        rd_r      <= req.rd;
                        wb_r      <= req.wb;
                        reg_idx_r <= req.rs1;
                        reg_en_r  <= (req.rs1 != 5'd0);
                        busy_r    <= 1'b1;
                        state_r   <= S_RD_A;
                    end else begin
                        state_r   <= S_IDLE;
                    end
                end
                S_RD_A: begin
                    op_a_r    <= (rs1_r == 5'd0) ? 32'd0 : bus;
                    reg_idx_r <= rs2_r;
                    reg_en_r  <= (rs2_r != 5'd0);
                    state_r   <= S_RD_B;
                end
                S_RD_B: begin
                    op_b_r       <= (rs2_r == 5'd0) ? 32'd0 : bus;
                    reg_en_r     <= 1'b0;
                    opnd_valid_r <= 1'b1;
                    state_r      <= S_WAIT;
                end
                S_WAIT: begin
                    if (req.result_valid) begin
                        wb_data_r    <= req.result;
                        opnd_valid_r <= 1'b0;
                        if (wb_r && (rd_r != 5'd0)) begin
                            reg_idx_r   <= rd_r;
                            reg_write_r <= 1'b1;
                            bus_oe_r    <= 1'b1;
                            state_r     <= S_WR;
                        end else begin
                            // Write-back not wanted or aimed at x0: skip WR.
                            done_r  <= 1'b1;
                            state_r <= S_FIN;
                        end
                    end else begin
                        state_r <= S_WAIT;
                    end
                end
                S_WR: begin
                    reg_write_r <= 1'b0;
                    bus_oe_r    <= 1'b0;
                    done_r      <= 1'b1;
                    state_r     <= S_FIN;
                end
                S_FIN: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    // Unreachable encoding: drop every strobe and recover.
                    busy_r       <= 1'b0;
                    opnd_valid_r <= 1'b0;
                    done_r       <= 1'b0;
                    bus_oe_r     <= 1'b0;
                    reg_en_r     <= 1'b0;
                    reg_write_r  <= 1'b0;
                    state_r      <= S_IDLE;
                end
            endcase
        end
    end

    // The bus is driven only while the WR-state flag is set; reg_en_r is
    // never set in that state, so the two drivers cannot overlap.
    assign bus = bus_oe_r ? wb_data_r : {32{1'bz}};

    assign reg_idx        = reg_idx_r;
    assign reg_en         = reg_en_r;
    assign reg_write      = reg_write_r;
    assign req.busy       = busy_r;
    assign req.op_a       = op_a_r;
    assign req.op_b       = op_b_r;
    assign req.opnd_valid = opnd_valid_r;
    assign req.done       = done_r;

endmodule

// File: tb/tb_regbus_sequencer.sv
// Directed testbench for regbus_sequencer with a behavioural register file
// on the tristate bus. Inputs change and outputs are sampled on the negedge.
module tb_regbus_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    regbus_sequencer_if rif();
    wire  [31:0] bus;
    logic [4:0]  reg_idx;
    logic        reg_en;
    logic        reg_write;

    logic [31:0] rf [32];
    logic        pre_en;
    logic [4:0]  pre_idx;
    logic [31:0] pre_data;

    int total = 0;
    int bad   = 0;
    int wr_cnt = 0;
    int w0;

    regbus_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (rif),
        .bus       (bus),
        .reg_idx   (reg_idx),
        .reg_en    (reg_en),
        .reg_write (reg_write)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Register file read drive onto the shared bus.
    assign bus = reg_en ? rf[reg_idx] : {32{1'bz}};

    // Register file storage: preload port, otherwise write strobe from the DUT.
    always @(posedge clk) begin
        if (pre_en) rf[pre_idx] <= pre_data;
        else if (reg_write) rf[reg_idx] <= bus;
    end

    // Per-cycle contention check and write-strobe counter.
    always @(negedge clk) begin
        total++;
        assert (!(reg_en && dut.bus_oe_r)) else begin
            bad++;
            $error("FAIL contention: reg_en=%0b drive=%0b expected not both", reg_en, dut.bus_oe_r);
        end
        if (reg_write) wr_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic preload(input logic [4:0] idx, input logic [31:0] data);
        pre_en = 1'b1; pre_idx = idx; pre_data = data;
        @(negedge clk);
        pre_en = 1'b0;
    endtask

    // Present a request for one cycle; returns in cycle N (RD_A).
    task automatic go(input logic [4:0] a, input logic [4:0] b, input logic [4:0] d, input logic w);
        rif.rs1 = a; rif.rs2 = b; rif.rd = d; rif.wb = w;
        rif.start = 1'b1;
        @(negedge clk);
        rif.start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        pre_en = 1'b0; pre_idx = 5'd0; pre_data = 32'd0;
        rif.start = 1'b0; rif.rs1 = 5'd0; rif.rs2 = 5'd0; rif.rd = 5'd0; rif.wb = 1'b0;
        rif.result = 32'd0; rif.result_valid = 1'b0;
        @(negedge clk);
        preload(5'd0,  32'h0000_0000);
        preload(5'd5,  32'h1111_1111);
        preload(5'd6,  32'h2222_2222);
        preload(5'd9,  32'h9999_9999);
        preload(5'd12, 32'hAAAA_0000);
        preload(5'd13, 32'hBBBB_0000);

        // Reset state
        chk("rst busy",  {31'd0, rif.busy}, 32'd0);
        chk("rst done",  {31'd0, rif.done}, 32'd0);
        chk("rst ovld",  {31'd0, rif.opnd_valid}, 32'd0);
        chk("rst reg_en", {31'd0, reg_en}, 32'd0);
        chk("rst reg_wr", {31'd0, reg_write}, 32'd0);
        chk("rst idx",   {27'd0, reg_idx}, 32'd0);
        chk("rst op_a",  rif.op_a, 32'd0);
        chk("rst op_b",  rif.op_b, 32'd0);
        chk("rst drive", {31'd0, dut.bus_oe_r}, 32'd0);
        rst_n = 1'b1;
        cyc();

        // Scenario 1: full read/write-back at minimum latency
        rif.result = 32'h3333_3333; rif.result_valid = 1'b1;
        go(5'd5, 5'd6, 5'd7, 1'b1);
        chk("s1 rda busy", {31'd0, rif.busy}, 32'd1);
        chk("s1 rda idx", {27'd0, reg_idx}, 32'd5);
        chk("s1 rda en",  {31'd0, reg_en}, 32'd1);
        chk("s1 rda bus", bus, 32'h1111_1111);
        chk("s1 rda ovld", {31'd0, rif.opnd_valid}, 32'd0);
        cyc();
        chk("s1 rdb idx", {27'd0, reg_idx}, 32'd6);
        chk("s1 rdb op_a", rif.op_a, 32'h1111_1111);
        chk("s1 rdb ovld", {31'd0, rif.opnd_valid}, 32'd0);
        cyc();
        chk("s1 wait ovld", {31'd0, rif.opnd_valid}, 32'd1);
        chk("s1 wait op_b", rif.op_b, 32'h2222_2222);
        chk("s1 wait en", {31'd0, reg_en}, 32'd0);
        cyc();
        chk("s1 wr strobe", {31'd0, reg_write}, 32'd1);
        chk("s1 wr idx", {27'd0, reg_idx}, 32'd7);
        chk("s1 wr bus", bus, 32'h3333_3333);
        chk("s1 wr done", {31'd0, rif.done}, 32'd0);
        cyc();
        chk("s1 fin done", {31'd0, rif.done}, 32'd1);
        chk("s1 fin strobe", {31'd0, reg_write}, 32'd0);
        chk("s1 reg7", rf[7], 32'h3333_3333);
        cyc();
        chk("s1 idle busy", {31'd0, rif.busy}, 32'd0);
        chk("s1 idle done", {31'd0, rif.done}, 32'd0);

        // Scenario 2: both sources are x0
        go(5'd0, 5'd0, 5'd8, 1'b0);
        chk("s2 rda en", {31'd0, reg_en}, 32'd0);
        chk("s2 rda drive", {31'd0, dut.bus_oe_r}, 32'd0);
        cyc();
        chk("s2 rdb en", {31'd0, reg_en}, 32'd0);
        chk("s2 rdb drive", {31'd0, dut.bus_oe_r}, 32'd0);
        chk("s2 op_a", rif.op_a, 32'd0);
        cyc();
        chk("s2 op_b", rif.op_b, 32'd0);
        cyc();
        chk("s2 fin n+3", {31'd0, rif.done}, 32'd1);
        cyc();

        // Scenario 3a: write-back to x0 is suppressed
        w0 = wr_cnt;
        rif.result = 32'hDEAD_BEEF;
        go(5'd5, 5'd6, 5'd0, 1'b1);
        cyc(); cyc(); cyc();
        chk("s3a fin n+3", {31'd0, rif.done}, 32'd1);
        chk("s3a strobe", {31'd0, reg_write}, 32'd0);
        cyc();
        chk("s3a pulses", wr_cnt - w0, 32'd0);
        chk("s3a reg0", rf[0], 32'd0);

        // Scenario 3b: no write-back requested
        w0 = wr_cnt;
        go(5'd5, 5'd6, 5'd9, 1'b0);
        cyc(); cyc(); cyc();
        chk("s3b fin n+3", {31'd0, rif.done}, 32'd1);
        cyc();
        chk("s3b pulses", wr_cnt - w0, 32'd0);
        chk("s3b reg9", rf[9], 32'h9999_9999);

        // Scenario 4: long WAIT with a stray start
        rif.result_valid = 1'b0; rif.result = 32'h4444_4444;
        go(5'd5, 5'd6, 5'd10, 1'b1);
        cyc(); cyc();
        for (int i = 0; i < 10; i++) begin
            chk("s4 wait busy", {31'd0, rif.busy}, 32'd1);
            chk("s4 wait ovld", {31'd0, rif.opnd_valid}, 32'd1);
            if (i == 3) begin rif.start = 1'b1; rif.rd = 5'd11; end
            if (i == 5) rif.start = 1'b0;
            cyc();
        end
        rif.result_valid = 1'b1;
        cyc();
        rif.result_valid = 1'b0; rif.result = 32'd0;
        chk("s4 wr strobe", {31'd0, reg_write}, 32'd1);
        chk("s4 wr idx", {27'd0, reg_idx}, 32'd10);
        chk("s4 wr bus", bus, 32'h4444_4444);
        cyc();
        chk("s4 fin done", {31'd0, rif.done}, 32'd1);
        chk("s4 reg10", rf[10], 32'h4444_4444);
        cyc();
        chk("s4 idle busy", {31'd0, rif.busy}, 32'd0);
        cyc();
        chk("s4 not queued", {31'd0, rif.busy}, 32'd0);

        // Scenario 5a: reset during WR
        rif.result_valid = 1'b1; rif.result = 32'h5555_5555;
        go(5'd5, 5'd6, 5'd12, 1'b1);
        cyc(); cyc(); cyc();
        chk("s5a in wr", {31'd0, reg_write}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("s5a strobe", {31'd0, reg_write}, 32'd0);
        chk("s5a drive", {31'd0, dut.bus_oe_r}, 32'd0);
        chk("s5a busy", {31'd0, rif.busy}, 32'd0);
        chk("s5a idx", {27'd0, reg_idx}, 32'd0);
        chk("s5a op_a", rif.op_a, 32'd0);
        chk("s5a op_b", rif.op_b, 32'd0);
        chk("s5a ovld", {31'd0, rif.opnd_valid}, 32'd0);
        @(negedge clk);
        chk("s5a reg12", rf[12], 32'hAAAA_0000);
        rst_n = 1'b1;
        cyc();
        chk("s5a after busy", {31'd0, rif.busy}, 32'd0);

        // Scenario 5b: reset during RD_B
        go(5'd5, 5'd6, 5'd13, 1'b1);
        cyc();
        chk("s5b in rdb", {31'd0, reg_en}, 32'd1);
        chk("s5b op_a", rif.op_a, 32'h1111_1111);
        #2 rst_n = 1'b0;
        #1;
        chk("s5b reg_en", {31'd0, reg_en}, 32'd0);
        chk("s5b idx", {27'd0, reg_idx}, 32'd0);
        chk("s5b op_a rst", rif.op_a, 32'd0);
        chk("s5b busy", {31'd0, rif.busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(); cyc(); cyc(); cyc();
        chk("s5b idle", {31'd0, rif.busy}, 32'd0);
        chk("s5b reg13", rf[13], 32'hBBBB_0000);

        // Scenario 6: back-to-back with start held high
        rif.result_valid = 1'b1; rif.result = 32'h6666_6666;
        rif.rs1 = 5'd5; rif.rs2 = 5'd6; rif.rd = 5'd14; rif.wb = 1'b1;
        rif.start = 1'b1;
        cyc();
        rif.rd = 5'd15;
        chk("s6 t1 busy", {31'd0, rif.busy}, 32'd1);
        cyc(); cyc(); cyc();
        chk("s6 t1 wr idx", {27'd0, reg_idx}, 32'd14);
        chk("s6 t1 strobe", {31'd0, reg_write}, 32'd1);
        cyc();
        chk("s6 t1 done", {31'd0, rif.done}, 32'd1);
        cyc();
        chk("s6 gap busy", {31'd0, rif.busy}, 32'd0);
        chk("s6 gap done", {31'd0, rif.done}, 32'd0);
        cyc();
        chk("s6 t2 busy", {31'd0, rif.busy}, 32'd1);
        chk("s6 t2 idx", {27'd0, reg_idx}, 32'd5);
        cyc(); cyc(); cyc();
        chk("s6 t2 wr idx", {27'd0, reg_idx}, 32'd15);
        chk("s6 t2 strobe", {31'd0, reg_write}, 32'd1);
        rif.start = 1'b0;
        cyc();
        chk("s6 t2 done", {31'd0, rif.done}, 32'd1);
        cyc();
        chk("s6 reg14", rf[14], 32'h6666_6666);
        chk("s6 reg15", rf[15], 32'h6666_6666);
        chk("s6 end busy", {31'd0, rif.busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
